bcd_add_controller: RTL and testbench

Sequencing FSM that sits directly upstream of the BCD-add datapath in the lab-2 adder. It turns a single user "enter" push-button into the command sequence init → load A → display A → load B → display B → display sum LS → display sum MS, repeating. Each command is issued to the datapath over a level request/acknowledge handshake. The block debounces the button, tracks progress on a phase output, and latches an error if the datapath stops acknowledging.

---
 rtl/bcd_add_controller.sv | 211 +++++++++++++++++++++
 tb/tb_bcd_add_controller.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_add_controller.sv
// Command sequencer for the lab-2 BCD-add datapath: debounces the enter button and
// walks init/load/display commands over a sticky level request/acknowledge handshake.
module bcd_add_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT     = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enter,
    output logic       init,
    output logic       load_a,
    output logic       load_b,
    output logic       display_a,
    output logic       display_b,
    output logic       display_ls,
    output logic       display_ms,
    input  logic       init_ack,
    input  logic       load_a_ack,
    input  logic       load_b_ack,
    input  logic       display_a_ack,
    input  logic       display_b_ack,
    input  logic       display_ls_ack,
    input  logic       display_ms_ack,
    output logic [2:0] phase,
    output logic       error
);

    localparam logic [15:0] DB_LIMIT = 16'(DEBOUNCE_CYCLES);
    localparam logic [7:0]  TO_LIMIT = 8'(ACK_TIMEOUT);

    // Request vector bit positions
    localparam int unsigned R_INIT = 0;
    localparam int unsigned R_LA   = 1;
    localparam int unsigned R_LB   = 2;
    localparam int unsigned R_DA   = 3;
    localparam int unsigned R_DB   = 4;
    localparam int unsigned R_LS   = 5;
    localparam int unsigned R_MS   = 6;

    typedef enum logic [3:0] {
        S_REQ_INIT,
        S_WAIT_A,
        S_REQ_LOAD_A,
        S_REQ_DISP_A,
        S_WAIT_B,
        S_REQ_LOAD_B,
        S_REQ_DISP_B,
        S_WAIT_LS,
        S_REQ_DISP_LS,
        S_WAIT_MS,
        S_REQ_DISP_MS,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic        sync1, sync2;
    logic [15:0] db_count;
    logic        db_level, db_level_d;
    logic        press;
    logic [6:0]  req_q, req_d;
    logic [7:0]  to_count;
    logic        ack_sel;
    logic        in_req;
    logic        accept;
    logic        timeout;

    // Button path: synchronizer, debounce counter, rising-edge detector
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            db_count   <= '0;
            db_level   <= 1'b0;
            db_level_d <= 1'b0;
        end else begin
            sync1 <= enter;
            sync2 <= sync1;
            if (!sync2) begin
                db_count <= '0;
            end else if (db_count != DB_LIMIT) begin
                db_count <= db_count + 16'd1;
            end
            db_level   <= (db_count == DB_LIMIT);
            db_level_d <= db_level;
        end
    end

    assign press = db_level & ~db_level_d;

    // Only the ack matching the current request is ever looked at
    always_comb begin
        ack_sel = 1'b0;
        case (state_q)
            S_REQ_INIT:    ack_sel = init_ack;
            S_REQ_LOAD_A:  ack_sel = load_a_ack;
            S_REQ_DISP_A:  ack_sel = display_a_ack;
            S_REQ_LOAD_B:  ack_sel = load_b_ack;
            S_REQ_DISP_B:  ack_sel = display_b_ack;
            S_REQ_DISP_LS: ack_sel = display_ls_ack;
            S_REQ_DISP_MS: ack_sel = display_ms_ack;
            default:       ack_sel = 1'b0;
        endcase
    end

    // to_count is zero exactly in the first cycle a request is visible, which
    // masks an ack left high from the previous command.
    assign in_req  = (req_q != '0);
    assign accept  = in_req && (to_count != '0) && ack_sel;
    assign timeout = in_req && !accept && (to_count == TO_LIMIT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ_INIT: begin
                if (accept)       state_d = S_WAIT_A;
                else if (timeout) state_d = S_ERROR;
            end
            S_WAIT_A: begin
                if (press) state_d = S_REQ_LOAD_A;
            end
            S_REQ_LOAD_A: begin
                if (accept)       state_d = S_REQ_DISP_A;
                else if (timeout) state_d = S_ERROR;
            end
            S_REQ_DISP_A: begin
                if (accept)       state_d = S_WAIT_B;
                else if (timeout) state_d = S_ERROR;
            end
            S_WAIT_B: begin
                if (press) state_d = S_REQ_LOAD_B;
            end
            S_REQ_LOAD_B: begin
                if (accept)       state_d = S_REQ_DISP_B;
                else if (timeout) state_d = S_ERROR;
            end
            S_REQ_DISP_B: begin
                if (accept)       state_d = S_WAIT_LS;
                else if (timeout) state_d = S_ERROR;
            end
            S_WAIT_LS: begin
                if (press) state_d = S_REQ_DISP_LS;
            end
            S_REQ_DISP_LS: begin
                if (accept)       state_d = S_WAIT_MS;
                else if (timeout) state_d = S_ERROR;
            end
            S_WAIT_MS: begin
                if (press) state_d = S_REQ_DISP_MS;
            end
            S_REQ_DISP_MS: begin
                if (accept)       state_d = S_WAIT_A;
                else if (timeout) state_d = S_ERROR;
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    // Requests are registered from the next state so they move on the same edge as the FSM
    always_comb begin
        req_d = '0;
        case (state_d)
            S_REQ_INIT:    req_d[R_INIT] = 1'b1;
            S_REQ_LOAD_A:  req_d[R_LA]   = 1'b1;
            S_REQ_DISP_A:  req_d[R_DA]   = 1'b1;
            S_REQ_LOAD_B:  req_d[R_LB]   = 1'b1;
            S_REQ_DISP_B:  req_d[R_DB]   = 1'b1;
            S_REQ_DISP_LS: req_d[R_LS]   = 1'b1;
            S_REQ_DISP_MS: req_d[R_MS]   = 1'b1;
            default:       req_d         = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_REQ_INIT;
            req_q    <= '0;
            to_count <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            if (req_d == '0 || req_d != req_q) begin
                to_count <= '0;
            end else if (to_count != 8'hFF) begin
                to_count <= to_count + 8'd1;
            end
        end
    end

    always_comb begin
        phase = 3'd0;
        case (state_q)
            S_REQ_INIT:                               phase = 3'd0;
            S_WAIT_A, S_REQ_LOAD_A, S_REQ_DISP_A:     phase = 3'd1;
            S_WAIT_B, S_REQ_LOAD_B, S_REQ_DISP_B:     phase = 3'd2;
            S_WAIT_LS, S_REQ_DISP_LS:                 phase = 3'd3;
            S_WAIT_MS, S_REQ_DISP_MS:                 phase = 3'd4;
            default:                                  phase = 3'd7;
        endcase
    end

    assign error      = (state_q == S_ERROR);
    assign init       = req_q[R_INIT];
    assign load_a     = req_q[R_LA];
    assign load_b     = req_q[R_LB];
    assign display_a  = req_q[R_DA];
    assign display_b  = req_q[R_DB];
    assign display_ls = req_q[R_LS];
    assign display_ms = req_q[R_MS];

endmodule

// File: tb/tb_bcd_add_controller.sv
// Self-checking bench for bcd_add_controller: directed vector table, hand-written
// corner sequences, and randomized presses against a transaction-level timing model.
module tb_bcd_add_controller;

    localparam int unsigned DB = 4;
    localparam int unsigned TO = 15;

    localparam logic [6:0] C_INIT = 7'b0000001;
    localparam logic [6:0] C_LA   = 7'b0000010;
    localparam logic [6:0] C_LB   = 7'b0000100;
    localparam logic [6:0] C_DA   = 7'b0001000;
    localparam logic [6:0] C_DB   = 7'b0010000;
    localparam logic [6:0] C_LS   = 7'b0100000;
    localparam logic [6:0] C_MS   = 7'b1000000;

    logic clock = 1'b0;
    logic reset, enter;
    logic init, load_a, load_b, display_a, display_b, display_ls, display_ms;
    logic [2:0] phase;
    logic error;
    logic [6:0] ack_reg, ack_force, acks, reqv;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign acks = ack_reg | ack_force;
    assign reqv = {display_ms, display_ls, display_b, display_a, load_b, load_a, init};

    bcd_add_controller #(.DEBOUNCE_CYCLES(DB), .ACK_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .enter(enter),
        .init(init), .load_a(load_a), .load_b(load_b), .display_a(display_a),
        .display_b(display_b), .display_ls(display_ls), .display_ms(display_ms),
        .init_ack(acks[0]), .load_a_ack(acks[1]), .load_b_ack(acks[2]),
        .display_a_ack(acks[3]), .display_b_ack(acks[4]), .display_ls_ack(acks[5]),
        .display_ms_ack(acks[6]),
        .phase(phase), .error(error)
    );

    // Posedge counter: at a negedge, cyc is the number of the edge just taken
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Datapath model: registers a sticky ack dp_delay edges after it first sees a command
    int         dp_delay = 1;
    logic [6:0] dp_hold  = '0;
    logic [6:0] last_cmd;
    int         dp_wait;
    always @(posedge clock) begin
        if (reset) begin
            ack_reg  <= '0;
            last_cmd <= '0;
            dp_wait  <= 0;
        end else begin
            last_cmd <= reqv;
            if (reqv != '0 && reqv != last_cmd) begin
                dp_wait <= 1;
                ack_reg <= (dp_delay <= 1 && (reqv & dp_hold) == '0) ? reqv : '0;
            end else if (reqv != '0 && ack_reg != reqv) begin
                dp_wait <= dp_wait + 1;
                if (dp_wait + 1 >= dp_delay && (reqv & dp_hold) == '0) ack_reg <= reqv;
            end
        end
    end

    // Request pulse monitor
    typedef struct {
        logic [6:0] cmd;
        int         rise;
        int         fall;
    } pulse_t;

    pulse_t     obs[$];
    logic [6:0] prev_req = '0;
    int         rise_at = 0;
    int         onehot_bad = 0;
    always @(negedge clock) begin
        if (!$onehot0(reqv)) onehot_bad = onehot_bad + 1;
        if (prev_req != '0 && reqv != prev_req) obs.push_back('{prev_req, rise_at, cyc});
        if (reqv != '0 && reqv != prev_req) rise_at = cyc;
        prev_req = reqv;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input int hold, output int e0);
        e0 = cyc + 1;
        enter = 1'b1;
        tick(hold);
        enter = 1'b0;
    endtask

    task automatic check_pulse(input string name, input int idx, input logic [6:0] cmd,
                               input int rise, input int fall);
        if (idx >= obs.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: pulse missing, expected cmd %b rise %0d fall %0d", name, cmd, rise, fall);
        end else begin
            check({name, "_cmd"}, 32'(obs[idx].cmd), 32'(cmd));
            check({name, "_rise"}, obs[idx].rise, rise);
            check({name, "_fall"}, obs[idx].fall, fall);
        end
    endtask

    typedef struct {
        int         hold;
        int         delay;
        int         npulses;
        logic [6:0] first_cmd;
        logic [6:0] second_cmd;
        int         rise_off;
        logic [2:0] phase_after;
    } vec_t;

    vec_t       vecs[6];
    pulse_t     expq[$];
    logic [6:0] grp[4][2];
    int         glen[4];
    int         base, e0, e1, rel, f_edge, wstate, p, r;

    function automatic logic [2:0] wait_phase(input int ws);
        return 3'(ws + 1);
    endfunction

    initial begin
        vecs[0] = '{3,  1, 0, 7'b0, 7'b0, 0, 3'd1};
        vecs[1] = '{20, 1, 2, C_LA, C_DA, 7, 3'd2};
        vecs[2] = '{4,  2, 2, C_LB, C_DB, 7, 3'd3};
        vecs[3] = '{1,  1, 0, 7'b0, 7'b0, 0, 3'd3};
        vecs[4] = '{6,  3, 1, C_LS, 7'b0, 7, 3'd4};
        vecs[5] = '{9,  1, 1, C_MS, 7'b0, 7, 3'd1};
        grp[0][0] = C_LA; grp[0][1] = C_DA; glen[0] = 2;
        grp[1][0] = C_LB; grp[1][1] = C_DB; glen[1] = 2;
        grp[2][0] = C_LS; grp[2][1] = 7'b0; glen[2] = 1;
        grp[3][0] = C_MS; grp[3][1] = 7'b0; glen[3] = 1;

        reset = 1'b1;
        enter = 1'b0;
        ack_force = '0;
        tick(3);
        check("reset_requests", 32'(reqv), 0);
        check("reset_phase", 32'(phase), 0);
        check("reset_error", 32'(error), 0);

        // Init handshake after release
        base = obs.size();
        reset = 1'b0;
        rel = cyc + 1;
        tick(1);
        check("init_asserted", 32'(reqv), 32'(C_INIT));
        tick(4);
        check_pulse("init_pulse", base, C_INIT, rel, rel + 2);
        check("init_phase_after", 32'(phase), 1);

        // Directed press table starting from WAIT_A
        for (int i = 0; i < 6; i++) begin
            dp_delay = vecs[i].delay;
            base = obs.size();
            press(vecs[i].hold, e0);
            tick(40);
            check($sformatf("vec%0d_npulses", i), obs.size() - base, vecs[i].npulses);
            if (vecs[i].npulses > 0 && obs.size() > base) begin
                check($sformatf("vec%0d_cmd", i), 32'(obs[base].cmd), 32'(vecs[i].first_cmd));
                check($sformatf("vec%0d_rise_off", i), obs[base].rise - e0, vecs[i].rise_off);
                check($sformatf("vec%0d_width", i), obs[base].fall - obs[base].rise, vecs[i].delay + 1);
            end
            if (vecs[i].npulses > 1 && obs.size() > base + 1) begin
                check($sformatf("vec%0d_cmd2", i), 32'(obs[base + 1].cmd), 32'(vecs[i].second_cmd));
                check($sformatf("vec%0d_back_to_back", i), obs[base + 1].rise, obs[base].fall);
            end
            check($sformatf("vec%0d_phase", i), 32'(phase), 32'(vecs[i].phase_after));
        end

        // Press landing inside REQ_DISP_A is discarded
        dp_delay = 5;
        base = obs.size();
        press(8, e0);
        tick(2);
        press(6, e1);
        tick(40);
        check("busy_press_second_start", e1, e0 + 10);
        check("busy_press_npulses", obs.size() - base, 2);
        check_pulse("busy_load_a", base, C_LA, e0 + 7, e0 + 13);
        check_pulse("busy_disp_a", base + 1, C_DA, e0 + 13, e0 + 19);
        check("busy_phase", 32'(phase), 2);

        // Advance to WAIT_MS, then stale sticky display_ms_ack
        dp_delay = 1;
        press(5, e0);
        tick(30);
        press(5, e0);
        tick(30);
        check("wait_ms_phase", 32'(phase), 4);
        ack_force = C_MS;
        dp_hold = C_MS;
        base = obs.size();
        press(5, e0);
        tick(30);
        check_pulse("stale_ack_ms", base, C_MS, e0 + 7, e0 + 9);
        check("stale_ack_phase", 32'(phase), 1);
        ack_force = '0;
        dp_hold = '0;

        // load_b never acknowledged: timeout to ERROR, presses then ignored
        press(5, e0);
        tick(30);
        dp_hold = C_LB;
        base = obs.size();
        press(5, e0);
        tick(30);
        check_pulse("timeout_load_b", base, C_LB, e0 + 7, e0 + 7 + TO + 1);
        check("timeout_error", 32'(error), 1);
        check("timeout_phase", 32'(phase), 7);
        base = obs.size();
        press(5, e0);
        tick(30);
        check("error_press_ignored", obs.size() - base, 0);
        check("error_sticky", 32'(error), 1);

        // Reset from ERROR, then reset while load_b is pending
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(6);
        check("error_cleared", 32'(error), 0);
        press(5, e0);
        tick(25);
        press(5, e0);
        tick(5);
        check("load_b_pending", 32'(reqv), 32'(C_LB));
        reset = 1'b1;
        dp_hold = '0;
        tick(1);
        check("midreset_requests", 32'(reqv), 0);
        check("midreset_phase", 32'(phase), 0);
        reset = 1'b0;
        rel = cyc + 1;
        tick(1);
        check("midreset_init", 32'(reqv), 32'(C_INIT));
        check("midreset_error", 32'(error), 0);
        tick(5);
        check("midreset_phase_after", 32'(phase), 1);
        f_edge = rel + 2;
        wstate = 0;

        // Randomized presses: a press pulse acts on edge e0+DB+3 and is taken only
        // if the previous command group finished strictly before that edge.
        for (int b = 0; b < 3; b++) begin
            dp_delay = 1 + 2 * b;
            base = obs.size();
            expq.delete();
            for (int k = 0; k < 12; k++) begin
                tick($urandom_range(1, 10));
                press($urandom_range(1, 9), e0);
                if (cyc - e0 + 1 >= DB) begin
                    p = e0 + DB + 3;
                    if (p > f_edge) begin
                        r = p;
                        for (int j = 0; j < glen[wstate]; j++) begin
                            expq.push_back('{grp[wstate][j], r, r + dp_delay + 1});
                            r = r + dp_delay + 1;
                        end
                        f_edge = r;
                        wstate = (wstate + 1) % 4;
                    end
                end
            end
            tick(40);
            check($sformatf("rand%0d_count", b), obs.size() - base, expq.size());
            for (int j = 0; j < expq.size() && base + j < obs.size(); j++) begin
                check_pulse($sformatf("rand%0d_p%0d", b, j), base + j, expq[j].cmd, expq[j].rise, expq[j].fall);
            end
            check($sformatf("rand%0d_phase", b), 32'(phase), 32'(wait_phase(wstate)));
        end

        check("onehot_violations", onehot_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
